image_streamer: RTL and testbench

Reads a finished 64x64 8-bit output image out of image memory and emits it as a pixel stream with a valid/ready handshake. It is the reader for the image writer: the filter/mirror/rotate engine writes the output image through its `out_row`/`out_col`/`out_we`/`out_pix` port, raises `done`, and this block then walks that memory and ships every pixel downstream. It supports raster order or column-major order, and sustains one pixel per cycle when the sink never stalls.

---
 rtl/image_streamer.sv | 145 ++++++++++++++
 tb/tb_image_streamer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/image_streamer.sv
// rtl/image_streamer.sv - streams a finished image out of memory with a valid/ready handshake
module image_streamer #(
  parameter int WIDTH  = 64,
  parameter int HEIGHT = 64,
  parameter int AW     = 6,
  parameter int PW     = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          order,
  output logic [AW-1:0] rd_row,
  output logic [AW-1:0] rd_col,
  input  logic [PW-1:0] rd_pix,
  output logic [PW-1:0] tx_pix,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic          tx_last,
  output logic          busy,
  output logic          finished
);

  localparam logic [AW-1:0] ROW_MAX = AW'(HEIGHT - 1);
  localparam logic [AW-1:0] COL_MAX = AW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, FIN} state_t;

  state_t        state, state_nxt;
  logic          start_q;
  logic          order_q;
  logic          start_edge;
  logic          at_end;
  logic          launch;
  logic          capture;
  logic          close;
  logic [AW-1:0] row_nxt;
  logic [AW-1:0] col_nxt;

  assign start_edge = start && !start_q;
  assign at_end     = (rd_row == ROW_MAX) && (rd_col == COL_MAX);

  // Next read address for the latched scan order; holds once the final pixel is reached
  always_comb begin
    row_nxt = rd_row;
    col_nxt = rd_col;
    if (!at_end) begin
      if (!order_q) begin
        if (rd_col == COL_MAX) begin
          col_nxt = '0;
          row_nxt = rd_row + AW'(1);
        end else begin
          col_nxt = rd_col + AW'(1);
        end
      end else begin
        if (rd_row == ROW_MAX) begin
          row_nxt = '0;
          col_nxt = rd_col + AW'(1);
        end else begin
          row_nxt = rd_row + AW'(1);
        end
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and datapath strobes; a capture in SEND only happens on a non-final transfer
  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    capture   = 1'b0;
    close     = 1'b0;
    case (state)
      IDLE: begin
        if (start_edge) begin
          launch    = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        capture   = 1'b1;
        state_nxt = SEND;
      end
      SEND: begin
        if (tx_valid && tx_ready) begin
          if (tx_last) begin
            close     = 1'b1;
            state_nxt = FIN;
          end else begin
            capture = 1'b1;
          end
        end
      end
      FIN: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Registered outputs, read address and start/order tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q  <= 1'b0;
      order_q  <= 1'b0;
      rd_row   <= '0;
      rd_col   <= '0;
      tx_pix   <= '0;
      tx_valid <= 1'b0;
      tx_last  <= 1'b0;
      busy     <= 1'b0;
      finished <= 1'b0;
    end else begin
      start_q  <= start;
      finished <= 1'b0;
      if (launch) begin
        order_q <= order;
        rd_row  <= '0;
        rd_col  <= '0;
        busy    <= 1'b1;
      end
      if (capture) begin
        tx_pix   <= rd_pix;
        tx_valid <= 1'b1;
        tx_last  <= at_end;
        rd_row   <= row_nxt;
        rd_col   <= col_nxt;
      end
      if (close) begin
        tx_valid <= 1'b0;
        tx_last  <= 1'b0;
        busy     <= 1'b0;
        finished <= 1'b1;
      end
      if (state == FIN) begin
        rd_row <= '0;
        rd_col <= '0;
      end
    end
  end

endmodule

// File: tb/tb_image_streamer.sv
// tb/tb_image_streamer.sv - scoreboard bench for image_streamer
module tb_image_streamer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       order;
  logic [5:0] rd_row;
  logic [5:0] rd_col;
  logic [7:0] rd_pix;
  logic [7:0] tx_pix;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_last;
  logic       busy;
  logic       finished;

  typedef struct {
    logic [7:0] pix;
    logic       last;
  } beat_t;

  beat_t      exp_q[$];
  int         checks;
  int         failures;
  int         beat_idx;
  int         fin_cnt;
  logic [7:0] got_pix[4096];
  logic       got_last[4096];

  int spot_idx[5] = '{0, 1, 2, 64, 4095};
  int spot_ras[5] = '{0, 1, 2, 64, 255};
  int spot_col[5] = '{0, 64, 128, 1, 255};

  image_streamer #(.WIDTH(64), .HEIGHT(64), .AW(6), .PW(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .order    (order),
    .rd_row   (rd_row),
    .rd_col   (rd_col),
    .rd_pix   (rd_pix),
    .tx_pix   (tx_pix),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_last  (tx_last),
    .busy     (busy),
    .finished (finished)
  );

  // image memory: pixel (r,c) = (r*64+c) mod 256
  assign rd_pix = {rd_row[1:0], rd_col};

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // monitor: pops the scoreboard on every transfer, counts finished pulses
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (finished) fin_cnt++;
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL extra_beat got=%0d exp=none", tx_pix);
        end else begin
          e = exp_q.pop_front();
          chk("beat_pix", int'(tx_pix), int'(e.pix));
          chk("beat_last", int'(tx_last), int'(e.last));
        end
        if (beat_idx < 4096) begin
          got_pix[beat_idx]  = tx_pix;
          got_last[beat_idx] = tx_last;
        end
        beat_idx++;
      end
    end
  end

  task automatic push_frame(input bit ord);
    exp_q.delete();
    for (int i = 0; i < 4096; i++) begin
      int    r, c;
      beat_t b;
      if (ord) begin c = i / 64; r = i % 64; end
      else     begin r = i / 64; c = i % 64; end
      b.pix  = 8'((r * 64 + c) % 256);
      b.last = (i == 4095);
      exp_q.push_back(b);
    end
  endtask

  task automatic wait_beats(input int target);
    int n;
    n = 0;
    while (beat_idx < target && n < 6000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("beat_reached", int'(beat_idx >= target), 1);
  endtask

  // mode: 0 plain, 1 backpressure, 2 start/order mid-frame, 3 start held high
  task automatic frame(input bit ord, input int mode);
    int base;
    int n;
    push_frame(ord);
    beat_idx = 0;
    base     = fin_cnt;
    @(posedge clk); #1;
    order = ord;
    start = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("valid_after_e0", int'(tx_valid), 0);
    chk("busy_after_e0", int'(busy), 1);
    @(posedge clk); @(negedge clk);
    chk("valid_after_e1", int'(tx_valid), 1);
    chk("first_pix", int'(tx_pix), 0);
    @(posedge clk); #1;
    if (mode != 3) start = 1'b0;
    if (mode == 1) begin
      wait_beats(10);
      tx_ready = 1'b0;
      repeat (5) begin
        @(negedge clk);
        chk("stall_pix", int'(tx_pix), 10);
        chk("stall_valid", int'(tx_valid), 1);
      end
      @(posedge clk); #1;
      tx_ready = 1'b1;
    end
    if (mode == 2) begin
      wait_beats(100);
      start = 1'b1;
      order = ~ord;
      @(posedge clk); #1;
      start = 1'b0;
    end
    n = 0;
    while (fin_cnt == base && n < 6000) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("fin_pulses", fin_cnt - base, 1);
    chk("beat_count", beat_idx, 4096);
    chk("queue_empty", exp_q.size(), 0);
    chk("busy_idle", int'(busy), 0);
    for (int k = 0; k < 5; k++)
      chk("spot_pix", int'(got_pix[spot_idx[k]]), ord ? spot_col[k] : spot_ras[k]);
    chk("spot_last", int'(got_last[4095]), 1);
    if (mode == 3) begin
      repeat (5800) @(posedge clk);
      #1;
      chk("held_fin_pulses", fin_cnt - base, 1);
      chk("held_beat_count", beat_idx, 4096);
      start = 1'b0;
    end
  endtask

  initial begin
    int base;
    clk      = 1'b0;
    rst_n    = 1'b0;
    start    = 1'b0;
    order    = 1'b0;
    tx_ready = 1'b1;
    checks   = 0;
    failures = 0;
    beat_idx = 0;
    fin_cnt  = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rd_row", int'(rd_row), 0);
    chk("rst_rd_col", int'(rd_col), 0);
    chk("rst_tx_pix", int'(tx_pix), 0);
    chk("rst_tx_valid", int'(tx_valid), 0);
    chk("rst_tx_last", int'(tx_last), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_finished", int'(finished), 0);
    rst_n = 1'b1;

    frame(1'b0, 0);
    frame(1'b1, 0);
    frame(1'b0, 1);
    frame(1'b0, 3);
    frame(1'b0, 2);

    // reset in the middle of a frame
    push_frame(1'b0);
    beat_idx = 0;
    base     = fin_cnt;
    @(posedge clk); #1;
    order = 1'b0;
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b0;
    wait_beats(2000);
    rst_n = 1'b0;
    #1;
    chk("midrst_rd_row", int'(rd_row), 0);
    chk("midrst_rd_col", int'(rd_col), 0);
    chk("midrst_tx_pix", int'(tx_pix), 0);
    chk("midrst_tx_valid", int'(tx_valid), 0);
    chk("midrst_tx_last", int'(tx_last), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_finished", int'(finished), 0);
    exp_q.delete();
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("midrst_no_fin", fin_cnt - base, 0);
    chk("midrst_idle_valid", int'(tx_valid), 0);

    frame(1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
